// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream FIFO: handshake helpers and a constant clog2 used for
// sizing pointers and the level port.
package stream_fifo_pkg;

  localparam logic HS_ASSERT   = 1'b1;
  localparam logic HS_DEASSERT = 1'b0;

  // Usable in parameter/localparam context, so it stays a plain constant function.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle. The producer side uses the master modport, the consumer
// side uses the slave modport.
interface stream_fifo_if #(
  parameter int unsigned W = 64
) ();

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/stream_fifo_ram.sv
// DEPTH x W flop array with one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module stream_fifo_ram
  import stream_fifo_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready FIFO with first-word-fall-through output. Defining STREAM_FIFO_OUTREG_EN adds a
// registered output stage (one extra entry of capacity, one extra edge of latency).
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AFULL = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_fifo_if.slave          s_in,
  stream_fifo_if.master         m_out,
  output logic [clog2(DEPTH):0] level,
  output logic                  almost_full
);

  localparam int unsigned AW = clog2(DEPTH) + 1;

  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_level;
  logic          r_init;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [W-1:0]  w_rdata;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-2:0] == r_rp[AW-2:0]) && (r_wp[AW-1] != r_rp[AW-1]);

  // r_init keeps iready low throughout reset and releases it on the first edge afterwards.
  assign s_in.ready = r_init & ~w_full;
  assign w_push     = hs_fire(s_in.valid, s_in.ready);

`ifdef STREAM_FIFO_OUTREG_EN
  logic         r_ovalid;
  logic [W-1:0] r_odata;

  // Refill the output stage whenever it is empty or being drained this cycle.
  assign w_pop = ~w_empty & (~r_ovalid | m_out.ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovalid <= HS_DEASSERT;
    end else if (w_pop) begin
      r_ovalid <= HS_ASSERT;
    end else if (m_out.ready) begin
      r_ovalid <= HS_DEASSERT;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_odata <= w_rdata;
    end
  end

  assign m_out.valid = r_ovalid;
  assign m_out.data  = r_odata;
`else
  assign m_out.valid = ~w_empty;
  assign m_out.data  = w_rdata;
  assign w_pop       = hs_fire(m_out.valid, m_out.ready);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_init <= 1'b1;
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + AW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - AW'(1);
      end
    end
  end

  assign level       = r_level;
  assign almost_full = (r_level >= AW'(AFULL));

  stream_fifo_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wp[AW-2:0]),
    .i_wdata (s_in.data),
    .i_raddr (r_rp[AW-2:0]),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo (default FWFT build): vector table for the fill phase,
// hand sequences for corner cases and a queue scoreboard for random traffic.
module tb_stream_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] level;
  logic       almost_full;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] q[$];

  stream_fifo_if #(.W(64)) in_if ();
  stream_fifo_if #(.W(64)) out_if ();

  stream_fifo #(
    .W     (64),
    .DEPTH (8),
    .AFULL (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in        (in_if),
    .m_out       (out_if),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ivalid;
    logic [63:0] data;
    logic        exp_ready_pre;
    logic [3:0]  exp_level;
    logic        exp_af;
    logic        exp_ready_post;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pop_check(input string name);
    logic [63:0] exp;
    if (q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got unexpected word %0h expected no output", name, out_if.data);
    end else begin
      exp = q.pop_front();
      check(name, out_if.data, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    int guard;

    for (int i = 0; i < 9; i++) begin
      vecs[i].ivalid         = 1'b1;
      vecs[i].data           = 64'(i + 1);
      vecs[i].exp_ready_pre  = (i < 8);
      vecs[i].exp_level      = (i < 8) ? 4'(i + 1) : 4'd8;
      vecs[i].exp_af         = ((i < 8) ? i + 1 : 8) >= 6;
      vecs[i].exp_ready_post = (i < 7);
    end

    // Reset held for three cycles
    rst          = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    repeat (3) tick();
    check("rst_ovalid", 64'(out_if.valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_iready", 64'(in_if.ready), 64'd0);
    check("rst_afull", 64'(almost_full), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_iready", 64'(in_if.ready), 64'd1);

    // Fill phase with oready low
    for (int i = 0; i < 9; i++) begin
      in_if.valid = vecs[i].ivalid;
      in_if.data  = vecs[i].data;
      #1;
      check($sformatf("fill%0d_ready_pre", i), 64'(in_if.ready), 64'(vecs[i].exp_ready_pre));
      if (in_if.valid && in_if.ready) q.push_back(in_if.data);
      tick();
      check($sformatf("fill%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("fill%0d_afull", i), 64'(almost_full), 64'(vecs[i].exp_af));
      check($sformatf("fill%0d_ready", i), 64'(in_if.ready), 64'(vecs[i].exp_ready_post));
    end

    // Full with ivalid and oready both high: only the pop happens
    in_if.valid  = 1'b1;
    in_if.data   = 64'h9;
    out_if.ready = 1'b1;
    #1;
    check("full_ovalid", 64'(out_if.valid), 64'd1);
    check("full_iready", 64'(in_if.ready), 64'd0);
    pop_check("full_pop_data");
    tick();
    check("full_pop_level", 64'(level), 64'd7);
    check("full_pop_iready", 64'(in_if.ready), 64'd1);
    out_if.ready = 1'b0;
    #1;
    if (in_if.valid && in_if.ready) q.push_back(in_if.data);
    tick();
    check("refill_level", 64'(level), 64'd8);
    in_if.valid = 1'b0;

    // Drain
    out_if.ready = 1'b1;
    guard = 0;
    while (out_if.valid && guard < 20) begin
      pop_check("drain_data");
      tick();
      guard++;
    end
    check("drain_level", 64'(level), 64'd0);
    check("drain_left", 64'(q.size()), 64'd0);

    // Push into empty FIFO with oready high: visible one edge later
    in_if.valid = 1'b1;
    in_if.data  = 64'hA5A5;
    #1;
    check("empty_ovalid_pre", 64'(out_if.valid), 64'd0);
    if (in_if.valid && in_if.ready) q.push_back(in_if.data);
    tick();
    in_if.valid = 1'b0;
    check("a5_ovalid", 64'(out_if.valid), 64'd1);
    pop_check("a5_data");
    tick();
    check("a5_level", 64'(level), 64'd0);
    check("a5_ovalid_after", 64'(out_if.valid), 64'd0);

    // Random traffic with scoreboard
    sent = 0;
    cyc  = 0;
    while ((sent < 3200 || q.size() != 0) && cyc < 30000) begin
      in_if.valid  = (sent < 3200) && ($urandom_range(0, 1) == 1);
      in_if.data   = {$urandom, $urandom};
      out_if.ready = ($urandom_range(0, 1) == 1);
      #1;
      if (out_if.valid && out_if.ready) pop_check("rand_data");
      if (in_if.valid && in_if.ready) begin
        q.push_back(in_if.data);
        sent++;
      end
      tick();
      cyc++;
      check("rand_level", 64'(level), 64'(q.size()));
    end
    if (cyc >= 30000) begin
      n_total++;
      $display("FAIL rand_timeout: got %0d words left expected 0", q.size());
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;

    // Reset mid-operation with five words held
    for (int i = 0; i < 5; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = 64'(16'h100 + i);
      #1;
      if (in_if.valid && in_if.ready) q.push_back(in_if.data);
      tick();
    end
    in_if.valid = 1'b0;
    check("pre_rst_level", 64'(level), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ovalid", 64'(out_if.valid), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    in_if.valid = 1'b1;
    in_if.data  = 64'h77;
    #1;
    check("rel_iready", 64'(in_if.ready), 64'd1);
    if (in_if.valid && in_if.ready) q.push_back(in_if.data);
    tick();
    in_if.valid = 1'b0;
    check("rel_ovalid", 64'(out_if.valid), 64'd1);
    pop_check("rel_first_word");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
